// File: rtl/sdram_bank_model.sv
// rtl/sdram_bank_model.sv - 4-bank SDRAM behavioural model with open-row tracking, tRCD checks and error flags
module sdram_bank_model #(
  parameter int ROW_BITS = 6,
  parameter int COL_BITS = 5,
  parameter int TRCD     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs,
  input  logic        ras,
  input  logic        cas,
  input  logic        we,
  input  logic [1:0]  bank_select,
  input  logic [13:0] dram_addr,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic [3:0]  bank_open,
  output logic        err,
  output logic [1:0]  err_code
);

  localparam int AW    = 2 + ROW_BITS + COL_BITS;
  localparam int DEPTH = 1 << AW;
  localparam int CW    = (TRCD < 2) ? 1 : $clog2(TRCD + 1);
  localparam logic [CW-1:0] TRCD_C = CW'(TRCD);

  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_RD  = 4'b0101;
  localparam logic [3:0] CMD_WR  = 4'b0100;
  localparam logic [3:0] CMD_MRS = 4'b0000;
  localparam logic [3:0] CMD_REF = 4'b0001;
  localparam logic [3:0] CMD_BST = 4'b0110;

  logic [31:0]         mem [DEPTH];
  logic [ROW_BITS-1:0] open_row [4];
  logic [CW-1:0]       act_cnt [4];
  logic                pend_valid;
  logic [AW-1:0]       pend_addr;

  logic [3:0]          cmd;
  logic                is_act, is_pre, is_rd, is_wr, is_bad;
  logic                sel_open, sel_early;
  logic [CW:0]         cnt_next;
  logic [AW-1:0]       acc_addr;

  // Upper address bits are not modelled.
  logic unused_addr;
  assign unused_addr = &{1'b0, dram_addr};

  always_comb begin
    cmd       = {cs, ras, cas, we};
    is_act    = (cmd == CMD_ACT);
    is_pre    = (cmd == CMD_PRE);
    is_rd     = (cmd == CMD_RD);
    is_wr     = (cmd == CMD_WR);
    is_bad    = (cmd == CMD_MRS) || (cmd == CMD_REF) || (cmd == CMD_BST);
    sel_open  = bank_open[bank_select];
    cnt_next  = {1'b0, act_cnt[bank_select]} + (CW + 1)'(1);
    sel_early = cnt_next < {1'b0, TRCD_C};
    acc_addr  = {bank_select, open_row[bank_select], dram_addr[COL_BITS-1:0]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      read_data  <= '0;
      bank_open  <= '0;
      err        <= 1'b0;
      err_code   <= 2'b00;
      pend_valid <= 1'b0;
      pend_addr  <= '0;
      for (int b = 0; b < 4; b++) begin
        act_cnt[b]  <= '0;
        open_row[b] <= '0;
      end
    end else begin
      pend_valid <= 1'b0;
      for (int b = 0; b < 4; b++) begin
        if (is_act && bank_select == 2'(b))
          act_cnt[b] <= '0;
        else if (act_cnt[b] != TRCD_C)
          act_cnt[b] <= act_cnt[b] + CW'(1);
      end
      if (is_act) begin
        open_row[bank_select]  <= dram_addr[ROW_BITS-1:0];
        bank_open[bank_select] <= 1'b1;
      end
      if (is_pre) begin
        if (dram_addr[10])
          bank_open <= '0;
        else
          bank_open[bank_select] <= 1'b0;
      end
      if (is_rd || is_wr) begin
        if (!sel_open) begin
          err      <= 1'b1;
          err_code <= 2'b01;
          if (is_rd)
            read_data <= 32'hDEAD_BEEF;
        end else begin
          if (sel_early) begin
            err      <= 1'b1;
            err_code <= 2'b10;
          end
          // Array read uses the pre-edge contents, giving read-before-write.
          if (is_rd)
            read_data <= mem[acc_addr];
          if (is_wr) begin
            pend_valid <= 1'b1;
            pend_addr  <= acc_addr;
          end
        end
      end
      if (is_bad) begin
        err      <= 1'b1;
        err_code <= 2'b11;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (pend_valid)
      mem[pend_addr] <= write_data;
  end

endmodule

// File: tb/tb_sdram_bank_model.sv
// tb/tb_sdram_bank_model.sv - scoreboard bench for sdram_bank_model command decode, data path and errors
module tb_sdram_bank_model;

  localparam logic [3:0] NOP = 4'b0111;
  localparam logic [3:0] ACT = 4'b0011;
  localparam logic [3:0] PRE = 4'b0010;
  localparam logic [3:0] RD  = 4'b0101;
  localparam logic [3:0] WR  = 4'b0100;
  localparam logic [3:0] REF = 4'b0001;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cs = 1'b1, ras = 1'b1, cas = 1'b1, we = 1'b1;
  logic [1:0]  bank_select = '0;
  logic [13:0] dram_addr = '0;
  logic [31:0] write_data = '0;
  logic [31:0] read_data;
  logic [3:0]  bank_open;
  logic        err;
  logic [1:0]  err_code;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q [$];
  string       tag_q [$];

  sdram_bank_model dut (
    .clk(clk), .rst(rst), .cs(cs), .ras(ras), .cas(cas), .we(we),
    .bank_select(bank_select), .dram_addr(dram_addr), .write_data(write_data),
    .read_data(read_data), .bank_open(bank_open), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Drive one command for one edge; READ results are popped from the scoreboard.
  task automatic step(input logic [3:0] c, input logic [1:0] b, input logic [13:0] a, input logic [31:0] wd);
    @(negedge clk);
    {cs, ras, cas, we} = c;
    bank_select = b;
    dram_addr   = a;
    write_data  = wd;
    @(posedge clk);
    #1;
    if (c == RD) begin
      if (exp_q.size() == 0)
        check("sb_empty", 32'd1, 32'd0);
      else
        check(tag_q.pop_front(), read_data, exp_q.pop_front());
    end
  endtask

  task automatic rd(input string tag, input logic [1:0] b, input logic [13:0] col, input logic [31:0] exp);
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    step(RD, b, col, 32'h0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_read_data", read_data, 32'h0);
    check("rst_bank_open", {28'h0, bank_open}, 32'h0);
    check("rst_err", {31'h0, err}, 32'h0);
    check("rst_err_code", {30'h0, err_code}, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // Basic write then read, bank 0 row 3 col 5
    step(ACT, 2'd0, 14'd3, 32'h0);
    step(NOP, 2'd0, 14'd0, 32'h0);
    step(WR,  2'd0, 14'd5, 32'h0);
    step(NOP, 2'd0, 14'd0, 32'hA5A5_1234);
    rd("rd_basic", 2'd0, 14'd5, 32'hA5A5_1234);
    check("basic_bank_open", {28'h0, bank_open}, 32'h1);
    check("basic_err", {31'h0, err}, 32'h0);

    // Read on the same edge as the pending store returns the old word
    step(WR, 2'd0, 14'd5, 32'h0);
    exp_q.push_back(32'hA5A5_1234);
    tag_q.push_back("rd_rbw_old");
    step(RD, 2'd0, 14'd5, 32'h5A5A_0000);
    rd("rd_rbw_new", 2'd0, 14'd5, 32'h5A5A_0000);

    // Two banks, same row and column, back-to-back writes
    step(ACT, 2'd2, 14'd3, 32'h0);
    step(NOP, 2'd0, 14'd0, 32'h0);
    step(WR,  2'd0, 14'd3, 32'h0);
    step(WR,  2'd2, 14'd3, 32'h1111_1111);
    step(NOP, 2'd0, 14'd0, 32'h2222_2222);
    rd("rd_b0c3", 2'd0, 14'd3, 32'h1111_1111);
    rd("rd_b2c3", 2'd2, 14'd3, 32'h2222_2222);
    check("two_bank_open", {28'h0, bank_open}, 32'h5);
    check("two_err", {31'h0, err}, 32'h0);

    // Closed-bank read
    rd("rd_closed_b1", 2'd1, 14'd0, 32'hDEAD_BEEF);
    check("closed_err", {31'h0, err}, 32'h1);
    check("closed_err_code", {30'h0, err_code}, 32'h1);

    // tRCD violation: data still returned
    step(ACT, 2'd3, 14'd7, 32'h0);
    step(NOP, 2'd0, 14'd0, 32'h0);
    step(WR,  2'd3, 14'd3, 32'h0);
    step(NOP, 2'd0, 14'd0, 32'h3333_3333);
    check("trcd_ok_code", {30'h0, err_code}, 32'h1);
    step(ACT, 2'd3, 14'd7, 32'h0);
    rd("rd_trcd_k1", 2'd3, 14'd3, 32'h3333_3333);
    check("trcd_err_code", {30'h0, err_code}, 32'h2);
    check("trcd_err_sticky", {31'h0, err}, 32'h1);

    // Precharge all, then read bank 0
    step(PRE, 2'd1, 14'h400, 32'h0);
    check("pall_bank_open", {28'h0, bank_open}, 32'h0);
    rd("rd_after_pall", 2'd0, 14'd5, 32'hDEAD_BEEF);
    check("pall_err_code", {30'h0, err_code}, 32'h1);

    // Unsupported command
    step(REF, 2'd0, 14'd0, 32'h0);
    check("ref_err_code", {30'h0, err_code}, 32'h3);

    // Reset between WRITE and its data edge cancels the store
    step(ACT, 2'd0, 14'd3, 32'h0);
    step(NOP, 2'd0, 14'd0, 32'h0);
    step(WR,  2'd0, 14'd5, 32'h0);
    @(negedge clk);
    {cs, ras, cas, we} = NOP;
    write_data = 32'hFFFF_FFFF;
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_err", {31'h0, err}, 32'h0);
    check("mid_rst_read_data", read_data, 32'h0);
    check("mid_rst_bank_open", {28'h0, bank_open}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    step(ACT, 2'd0, 14'd3, 32'h0);
    step(NOP, 2'd0, 14'd0, 32'h0);
    rd("rd_after_rst", 2'd0, 14'd5, 32'h5A5A_0000);
    check("after_rst_err", {31'h0, err}, 32'h0);
    check("sb_drained", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
